// File: rtl/qam_symbol_mapper_if.sv
// Sample bus between the bit-grouping stage and the subcarrier loader:
// bit group and modulation code in, signed I/Q subcarrier value out.
interface qam_symbol_mapper_if #(
    parameter int maxBitOrder = 6,
    parameter int fft_depth   = 12
);
    logic                        ival;
    logic [maxBitOrder-1:0]      bits;
    logic [2:0]                  index_M;
    logic signed [fft_depth-1:0] sub_i;
    logic signed [fft_depth-1:0] sub_q;
    logic                        oval;
    logic [2:0]                  oindex_M;

    modport master (
        output ival, bits, index_M,
        input  sub_i, sub_q, oval, oindex_M
    );

    modport slave (
        input  ival, bits, index_M,
        output sub_i, sub_q, oval, oindex_M
    );
endinterface

// File: rtl/qam_symbol_mapper.sv
// Registered Gray-coded BPSK/QPSK/QAM-16/QAM-64 mapper: one bit group per
// cycle becomes one signed I/Q pair one clock later.
module qam_symbol_mapper #(
    parameter int maxBitOrder = 6,
    parameter int fft_depth   = 12,
    parameter int A_QPSK      = 1024,
    parameter int A16_1       = 512,
    parameter int A16_3       = 1536,
    parameter int A64_1       = 256,
    parameter int A64_3       = 768,
    parameter int A64_5       = 1280,
    parameter int A64_7       = 1792
) (
    input logic                 clk,
    input logic                 rst,
    qam_symbol_mapper_if.slave  bus
);
    typedef logic [fft_depth-1:0] level_t;

    localparam level_t ZERO_C = {fft_depth{1'b0}};
    localparam level_t ONE_C  = {{(fft_depth-1){1'b0}}, 1'b1};
    localparam level_t L_QPSK = level_t'(A_QPSK);
    localparam level_t L16_1  = level_t'(A16_1);
    localparam level_t L16_3  = level_t'(A16_3);
    localparam level_t L64_1  = level_t'(A64_1);
    localparam level_t L64_3  = level_t'(A64_3);
    localparam level_t L64_5  = level_t'(A64_5);
    localparam level_t L64_7  = level_t'(A64_7);

    // The top bit of every Gray group is the sign: 1 keeps +L, 0 gives -L.
    function automatic level_t apply_sign(input logic pos, input level_t lvl);
        level_t r;
        if (pos) begin
            r = lvl;
        end else begin
            r = ~lvl + ONE_C;
        end
        return r;
    endfunction

    function automatic level_t map16(input logic [1:0] b);
        level_t r;
        case (b)
            2'b00:   r = apply_sign(1'b0, L16_3);
            2'b01:   r = apply_sign(1'b0, L16_1);
            2'b11:   r = apply_sign(1'b1, L16_1);
            2'b10:   r = apply_sign(1'b1, L16_3);
            default: r = ZERO_C;
        endcase
        return r;
    endfunction

    // Magnitude depends only on the low two bits, identically for both signs.
    function automatic level_t map64(input logic [2:0] b);
        level_t r;
        case (b[1:0])
            2'b00:   r = apply_sign(b[2], L64_7);
            2'b01:   r = apply_sign(b[2], L64_5);
            2'b11:   r = apply_sign(b[2], L64_3);
            2'b10:   r = apply_sign(b[2], L64_1);
            default: r = ZERO_C;
        endcase
        return r;
    endfunction

    level_t     sub_i_d, sub_i_q;
    level_t     sub_q_d, sub_q_q;
    logic       oval_d, oval_q;
    logic [2:0] oindex_M_d, oindex_M_q;

    // Next-state mapping; the code register only updates on valid samples.
    always_comb begin
        sub_i_d    = ZERO_C;
        sub_q_d    = ZERO_C;
        oval_d     = 1'b0;
        oindex_M_d = oindex_M_q;
        if (bus.ival) begin
            oval_d     = 1'b1;
            oindex_M_d = bus.index_M;
            case (bus.index_M)
                3'd1: begin
                    sub_i_d = apply_sign(bus.bits[0], L_QPSK);
                    sub_q_d = apply_sign(bus.bits[0], L_QPSK);
                end
                3'd2: begin
                    sub_i_d = apply_sign(bus.bits[1], L_QPSK);
                    sub_q_d = apply_sign(bus.bits[0], L_QPSK);
                end
                3'd4: begin
                    sub_i_d = map16(bus.bits[3:2]);
                    sub_q_d = map16(bus.bits[1:0]);
                end
                3'd6: begin
                    sub_i_d = map64(bus.bits[5:3]);
                    sub_q_d = map64(bus.bits[2:0]);
                end
                default: begin
                    sub_i_d = ZERO_C;
                    sub_q_d = ZERO_C;
                end
            endcase
        end else begin
            sub_i_d = ZERO_C;
            sub_q_d = ZERO_C;
            oval_d  = 1'b0;
        end
    end

    // Output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sub_i_q    <= ZERO_C;
            sub_q_q    <= ZERO_C;
            oval_q     <= 1'b0;
            oindex_M_q <= 3'd0;
        end else begin
            sub_i_q    <= sub_i_d;
            sub_q_q    <= sub_q_d;
            oval_q     <= oval_d;
            oindex_M_q <= oindex_M_d;
        end
    end

    assign bus.sub_i    = sub_i_q;
    assign bus.sub_q    = sub_q_q;
    assign bus.oval     = oval_q;
    assign bus.oindex_M = oindex_M_q;
endmodule

// File: tb/tb_qam_symbol_mapper.sv
// Directed bench for qam_symbol_mapper: hand-computed I/Q tables, one
// comparison group per sample, one clock of latency.
module tb_qam_symbol_mapper;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    qam_symbol_mapper_if #(.maxBitOrder(6), .fft_depth(12)) bus ();

    qam_symbol_mapper dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Gray level tables indexed by the raw bit code.
    int t16 [4] = '{-1536, -512, 1536, 512};
    int t64 [8] = '{-1792, -1280, -256, -768, 1792, 1280, 256, 768};

    task automatic check(input string tag, input int ei, input int eq,
                         input logic ev, input logic [2:0] em);
        logic [11:0] xi;
        logic [11:0] xq;
        xi = 12'(ei);
        xq = 12'(eq);
        total++;
        assert (bus.sub_i === xi && bus.sub_q === xq &&
                bus.oval === ev && bus.oindex_M === em)
        else begin
            bad++;
            $error("FAIL %s: got i=%h q=%h oval=%b idx=%0d expected i=%h q=%h oval=%b idx=%0d",
                   tag, bus.sub_i, bus.sub_q, bus.oval, bus.oindex_M, xi, xq, ev, em);
        end
    endtask

    // Drive one sample between edges, then sample just after the capturing edge.
    task automatic step(input logic v, input logic [5:0] b, input logic [2:0] m);
        @(negedge clk);
        bus.ival    = v;
        bus.bits    = b;
        bus.index_M = m;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] b;
        bus.ival    = 1'b0;
        bus.bits    = 6'd0;
        bus.index_M = 3'd0;

        #2 rst = 1'b0;
        #1 check("reset_state", 0, 0, 1'b0, 3'd0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 6'd0, 3'd0);
        check("idle_after_release", 0, 0, 1'b0, 3'd0);

        step(1'b1, 6'd0, 3'd2); check("qpsk_00", -1024, -1024, 1'b1, 3'd2);
        step(1'b1, 6'd1, 3'd2); check("qpsk_01", -1024,  1024, 1'b1, 3'd2);
        step(1'b1, 6'd2, 3'd2); check("qpsk_10",  1024, -1024, 1'b1, 3'd2);
        step(1'b1, 6'd3, 3'd2); check("qpsk_11",  1024,  1024, 1'b1, 3'd2);
        step(1'b1, 6'd1, 3'd1); check("bpsk_1",   1024,  1024, 1'b1, 3'd1);
        step(1'b1, 6'd0, 3'd1); check("bpsk_0",  -1024, -1024, 1'b1, 3'd1);
        step(1'b1, 6'h3E, 3'd1); check("bpsk_hi_ignored", -1024, -1024, 1'b1, 3'd1);

        for (int i = 0; i < 16; i++) begin
            b = 6'(i);
            step(1'b1, b, 3'd4);
            check("qam16_sweep", t16[b[3:2]], t16[b[1:0]], 1'b1, 3'd4);
        end
        step(1'b1, 6'b00_1000, 3'd4); check("qam16_1000", 1536, -1536, 1'b1, 3'd4);
        step(1'b1, 6'b00_0111, 3'd4); check("qam16_0111", -512, 512, 1'b1, 3'd4);

        for (int i = 0; i < 64; i++) begin
            b = 6'(i);
            step(1'b1, b, 3'd6);
            check("qam64_sweep", t64[b[5:3]], t64[b[2:0]], 1'b1, 3'd6);
        end
        step(1'b1, 6'b100_000, 3'd6); check("qam64_100000", 1792, -1792, 1'b1, 3'd6);
        step(1'b1, 6'b010_110, 3'd6); check("qam64_010110", -256, 256, 1'b1, 3'd6);

        step(1'b1, 6'h3F, 3'd6); check("switch_m6",  768,  768, 1'b1, 3'd6);
        step(1'b1, 6'h3F, 3'd4); check("switch_m4",  512,  512, 1'b1, 3'd4);
        step(1'b1, 6'h3F, 3'd2); check("switch_m2", 1024, 1024, 1'b1, 3'd2);
        step(1'b1, 6'h3F, 3'd1); check("switch_m1", 1024, 1024, 1'b1, 3'd1);
        step(1'b1, 6'h3F, 3'd3); check("switch_m3",    0,    0, 1'b1, 3'd3);
        step(1'b1, 6'h15, 3'd0); check("unsup_m0",     0,    0, 1'b1, 3'd0);
        step(1'b1, 6'h2A, 3'd5); check("unsup_m5",     0,    0, 1'b1, 3'd5);
        step(1'b1, 6'h3F, 3'd7); check("unsup_m7",     0,    0, 1'b1, 3'd7);

        step(1'b1, 6'h05, 3'd2); check("gate_on_a",  -1024, 1024, 1'b1, 3'd2);
        step(1'b0, 6'h05, 3'd6); check("gate_off",       0,    0, 1'b0, 3'd2);
        step(1'b1, 6'h05, 3'd2); check("gate_on_b",  -1024, 1024, 1'b1, 3'd2);

        step(1'b1, 6'h3F, 3'd6); check("pre_reset", 768, 768, 1'b1, 3'd6);
        #2 rst = 1'b0;
        #1 check("midstream_reset", 0, 0, 1'b0, 3'd0);
        @(negedge clk);
        rst = 1'b1;
        bus.ival = 1'b0;
        step(1'b0, 6'h00, 3'd6); check("post_release_idle", 0, 0, 1'b0, 3'd0);
        step(1'b1, 6'h00, 3'd6); check("post_release_first", -1792, -1792, 1'b1, 3'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
